// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the serial bus arbiter.
package bus_arb_pkg;

    localparam int MAX_MASTERS = 8;
    localparam int STATE_W     = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESUME = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] onehot,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Walk offsets from farthest to nearest so the nearest match is written last.
        for (int off = N - 1; off >= 0; off--) begin
            if (req[(int'(ptr) + off) % N]) begin
                onehot                           = '0;
                onehot[(int'(ptr) + off) % N]    = 1'b1;
                idx                              = W'((int'(ptr) + off) % N);
                any                              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Round-robin serial bus arbiter with a single outstanding split transaction.
module serial_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MSEL_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] mbreq,
    output logic [NUM_MASTERS-1:0] mbgrant,
    output logic [MSEL_W-1:0]      msel,
    output logic                   bus_busy,
    input  logic                   ssplit,
    output logic                   split_grant,
    output logic [NUM_MASTERS-1:0] msplit,
    output logic                   split_err
);

    // Handshake: a master raises mbreq and holds it for the whole transaction; it owns
    // the bus from the cycle mbgrant shows its bit until the cycle after it drops mbreq.

    state_t                   state_q, state_d;
    logic [MSEL_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic [MSEL_W-1:0]        owner_q, owner_d;
    logic [MSEL_W-1:0]        msel_q, msel_d;
    logic [NUM_MASTERS-1:0]   mbgrant_q, mbgrant_d;
    logic [NUM_MASTERS-1:0]   msplit_q, msplit_d;
    logic                     bus_busy_q, bus_busy_d;
    logic                     split_grant_q, split_grant_d;
    logic                     split_err_q, split_err_d;
    logic                     ssplit_q, ssplit_d;
    logic                     pending_q, pending_d;
    logic                     ready_q, ready_d;

    logic [NUM_MASTERS-1:0]   eligible;
    logic [NUM_MASTERS-1:0]   pick_onehot;
    logic [MSEL_W-1:0]        pick_idx;
    logic                     pick_any;
    logic                     split_rise;
    logic                     split_fall;

    assign eligible   = mbreq & ~msplit_q;
    assign split_rise = ssplit & ~ssplit_q;
    assign split_fall = pending_q & ssplit_q & ~ssplit;

    rr_picker #(
        .N (NUM_MASTERS),
        .W (MSEL_W)
    ) u_picker (
        .req    (eligible),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        msel_d        = msel_q;
        mbgrant_d     = mbgrant_q;
        msplit_d      = msplit_q;
        split_grant_d = 1'b0;
        split_err_d   = split_err_q | (split_rise & pending_q);
        ssplit_d      = ssplit;
        pending_d     = pending_q;
        ready_d       = ready_q | split_fall;

        case (state_q)
            IDLE: begin
                if (ready_q) begin
                    // The resumed master carries the grant, so the split mask is no longer needed.
                    state_d       = RESUME;
                    mbgrant_d     = msplit_q;
                    msel_d        = owner_q;
                    split_grant_d = 1'b1;
                    msplit_d      = '0;
                end else if (pick_any) begin
                    state_d   = BUSY;
                    mbgrant_d = pick_onehot;
                    msel_d    = pick_idx;
                    rr_ptr_d  = (pick_idx == MSEL_W'(NUM_MASTERS - 1)) ? '0
                                                                      : pick_idx + MSEL_W'(1);
                end
            end
            BUSY: begin
                if (split_rise) begin
                    if (!pending_q) begin
                        state_d   = IDLE;
                        msplit_d  = mbgrant_q;
                        owner_d   = msel_q;
                        pending_d = 1'b1;
                        mbgrant_d = '0;
                    end
                end else if (!mbreq[msel_q]) begin
                    state_d   = IDLE;
                    mbgrant_d = '0;
                end
            end
            RESUME: begin
                state_d   = BUSY;
                pending_d = 1'b0;
                ready_d   = 1'b0;
                msplit_d  = '0;
            end
            default: begin
                state_d   = IDLE;
                mbgrant_d = '0;
            end
        endcase

        bus_busy_d = |mbgrant_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            msel_q        <= '0;
            mbgrant_q     <= '0;
            msplit_q      <= '0;
            bus_busy_q    <= 1'b0;
            split_grant_q <= 1'b0;
            split_err_q   <= 1'b0;
            ssplit_q      <= 1'b0;
            pending_q     <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            msel_q        <= msel_d;
            mbgrant_q     <= mbgrant_d;
            msplit_q      <= msplit_d;
            bus_busy_q    <= bus_busy_d;
            split_grant_q <= split_grant_d;
            split_err_q   <= split_err_d;
            ssplit_q      <= ssplit_d;
            pending_q     <= pending_d;
            ready_q       <= ready_d;
        end
    end

    assign mbgrant     = mbgrant_q;
    assign msel        = msel_q;
    assign bus_busy    = bus_busy_q;
    assign split_grant = split_grant_q;
    assign msplit      = msplit_q;
    assign split_err   = split_err_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter: round-robin grants, split suspend/resume, reset.
module tb_serial_bus_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] mbreq;
    logic [1:0] mbgrant;
    logic [0:0] msel;
    logic       bus_busy;
    logic       ssplit;
    logic       split_grant;
    logic [1:0] msplit;
    logic       split_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];
    logic [1:0] exp_g;

    serial_bus_arbiter #(
        .NUM_MASTERS (2),
        .MSEL_W      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mbreq       (mbreq),
        .mbgrant     (mbgrant),
        .msel        (msel),
        .bus_busy    (bus_busy),
        .ssplit      (ssplit),
        .split_grant (split_grant),
        .msplit      (msplit),
        .split_err   (split_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [1:0] g, input logic s,
                            input logic sg, input logic [1:0] ms, input logic se);
        chk({tag, ".mbgrant"}, 32'(mbgrant), 32'(g));
        chk({tag, ".msel"}, 32'(msel), 32'(s));
        chk({tag, ".bus_busy"}, 32'(bus_busy), 32'(|g));
        chk({tag, ".split_grant"}, 32'(split_grant), 32'(sg));
        chk({tag, ".msplit"}, 32'(msplit), 32'(ms));
        chk({tag, ".split_err"}, 32'(split_err), 32'(se));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        mbreq  = 2'b00;
        ssplit = 1'b0;
        do_reset();
        chk_outs("reset", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

        // 1: single master request and release
        mbreq = 2'b01;
        tick();
        chk_outs("t1_grant", 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        mbreq = 2'b00;
        tick();
        chk_outs("t1_release", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);

        // 2: round-robin alternation from a fresh pointer
        do_reset();
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        for (int k = 0; k < 3; k++) begin
            mbreq = 2'b11;
            tick();
            exp_g = exp_q.pop_front();
            chk($sformatf("t2_grant%0d", k), 32'(mbgrant), 32'(exp_g));
            chk($sformatf("t2_busy%0d", k), 32'(bus_busy), 32'd1);
            mbreq = ~exp_g;
            tick();
            chk($sformatf("t2_release%0d", k), 32'(mbgrant), 32'd0);
        end
        mbreq = 2'b00;
        tick();
        chk("t2_idle", 32'(mbgrant), 32'd0);

        // 3: M0 granted (pointer wraps 1 -> 0), split suspends it, M1 gets the bus
        mbreq = 2'b01;
        tick();
        chk_outs("t3_m0", 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);
        ssplit = 1'b1;
        tick();
        chk_outs("t3_split", 2'b00, 1'b0, 1'b0, 2'b01, 1'b0);
        mbreq = 2'b11;
        tick();
        chk_outs("t3_m1", 2'b10, 1'b1, 1'b0, 2'b01, 1'b0);

        // 4: split ends during M1 ownership; resume after M1 releases
        ssplit = 1'b0;
        tick();
        chk_outs("t4_hold", 2'b10, 1'b1, 1'b0, 2'b01, 1'b0);
        mbreq = 2'b01;
        tick();
        chk_outs("t4_m1_done", 2'b00, 1'b1, 1'b0, 2'b01, 1'b0);
        tick();
        chk_outs("t4_resume", 2'b01, 1'b0, 1'b1, 2'b00, 1'b0);
        tick();
        chk_outs("t4_busy", 2'b01, 1'b0, 1'b0, 2'b00, 1'b0);

        // 5: split beats a simultaneous request drop; second rise while pending is an error
        ssplit = 1'b1;
        mbreq  = 2'b00;
        tick();
        chk_outs("t5_split", 2'b00, 1'b0, 1'b0, 2'b01, 1'b0);
        mbreq = 2'b10;
        tick();
        chk_outs("t5_m1", 2'b10, 1'b1, 1'b0, 2'b01, 1'b0);
        ssplit = 1'b0;
        tick();
        chk_outs("t5_fall", 2'b10, 1'b1, 1'b0, 2'b01, 1'b0);
        ssplit = 1'b1;
        tick();
        chk_outs("t5_err", 2'b10, 1'b1, 1'b0, 2'b01, 1'b1);

        // 6: asynchronous reset with a split pending
        #2;
        rst = 1'b1;
        #1;
        chk_outs("t6_async", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        ssplit = 1'b0;
        mbreq  = 2'b10;
        tick();
        rst = 1'b0;
        chk_outs("t6_in_rst", 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_outs("t6_regrant", 2'b10, 1'b1, 1'b0, 2'b00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
